fifo_lane_chk: RTL and testbench



---
 rtl/fifo_lane_chk.sv | 117 +++++++++++
 tb/tb_fifo_lane_chk.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_lane_chk.sv
// fifo_lane_chk: drains one lane's last FIFO and checks an incrementing pattern, counting ECC/mismatch errors.
// Latency: read strobe at t, data sampled at t+1, counters/err_o/locked_o visible at t+2.
// Backpressure: reads only while enabled and the FIFO is non-empty; never stalls, one word per cycle.
// Build option: define FIFO_CHK_RESYNC_EN to reseed the expected value from the received word on a mismatch.
module fifo_lane_chk #(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clear_i,
  input  logic             fifo_empty_i,
  output logic             fifo_rd_en_o,
  input  logic [N-1:0]     fifo_dout_i,
  input  logic             sbiterr_i,
  input  logic             dbiterr_i,
  output logic             locked_o,
  output logic [31:0]      word_cnt_o,
  output logic [CNT_W-1:0] mis_cnt_o,
  output logic [CNT_W-1:0] sbit_cnt_o,
  output logic [CNT_W-1:0] dbit_cnt_o,
  output logic             err_o
);

  typedef enum logic [1:0] {IDLE, SYNC, CHECK} state_t;

  state_t       state;
  logic [N-1:0] exp_r;
  logic         rd_vld_r;
  logic         chk_word;
  logic         hit_dbit;
  logic         hit_sbit;
  logic         hit_mis;

  // Read strobe is purely combinational so it drops in the same cycle empty rises.
  assign fifo_rd_en_o = en_i & ~fifo_empty_i & (state != IDLE);

  // Tracks which cycle carries valid FIFO data; reset drops any read in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) rd_vld_r <= 1'b0;
    else       rd_vld_r <= fifo_rd_en_o;
  end

  // Per-word events, only meaningful for words received while locked.
  always_comb begin
    chk_word = rd_vld_r & (state == CHECK);
    hit_dbit = chk_word & dbiterr_i;
    hit_sbit = chk_word & sbiterr_i;
    hit_mis  = chk_word & ~dbiterr_i & (fifo_dout_i != exp_r);
  end

  // Lock FSM and expected-value register; an in-flight word is always processed before IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      exp_r    <= '0;
      locked_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          locked_o <= 1'b0;
          if (en_i) state <= SYNC;
        end
        SYNC: begin
          if (rd_vld_r && !dbiterr_i) begin
            // First clean word seeds the pattern and is not itself checked.
            exp_r    <= fifo_dout_i + N'(1);
            state    <= CHECK;
            locked_o <= 1'b1;
          end else if (!en_i && !rd_vld_r) begin
            state    <= IDLE;
            locked_o <= 1'b0;
          end
        end
        CHECK: begin
          if (rd_vld_r) begin
            if (hit_mis) begin
`ifdef FIFO_CHK_RESYNC_EN
              exp_r <= fifo_dout_i + N'(1);
`else
              exp_r <= exp_r + N'(1);
`endif
            end else begin
              exp_r <= exp_r + N'(1);
            end
          end else if (!en_i) begin
            state    <= IDLE;
            locked_o <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          locked_o <= 1'b0;
        end
      endcase
    end
  end

  // Status counters and sticky error; clear takes priority over a coincident event.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      word_cnt_o <= '0;
      mis_cnt_o  <= '0;
      sbit_cnt_o <= '0;
      dbit_cnt_o <= '0;
      err_o      <= 1'b0;
    end else begin
      if (chk_word)                      word_cnt_o <= word_cnt_o + 32'd1;
      if (hit_mis  && (mis_cnt_o  != '1)) mis_cnt_o  <= mis_cnt_o  + CNT_W'(1);
      if (hit_sbit && (sbit_cnt_o != '1)) sbit_cnt_o <= sbit_cnt_o + CNT_W'(1);
      if (hit_dbit && (dbit_cnt_o != '1)) dbit_cnt_o <= dbit_cnt_o + CNT_W'(1);
      if (hit_mis || hit_dbit)           err_o      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_lane_chk.sv
// Bench for fifo_lane_chk: table of stream records plus hand sequences for clear and reset corner cases.
module tb_fifo_lane_chk;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_i = 1'b0;
  logic        clear_i;
  logic        clear_man = 1'b0;
  logic        clear_auto = 1'b0;
  logic        fifo_empty_i = 1'b1;
  logic        fifo_rd_en_o;
  logic [31:0] fifo_dout_i = '0;
  logic        sbiterr_i = 1'b0;
  logic        dbiterr_i = 1'b0;
  logic        locked_o;
  logic [31:0] word_cnt_o;
  logic [15:0] mis_cnt_o;
  logic [15:0] sbit_cnt_o;
  logic [15:0] dbit_cnt_o;
  logic        err_o;

  assign clear_i = clear_man | clear_auto;

  fifo_lane_chk #(.N(32), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .clear_i(clear_i),
    .fifo_empty_i(fifo_empty_i), .fifo_rd_en_o(fifo_rd_en_o), .fifo_dout_i(fifo_dout_i),
    .sbiterr_i(sbiterr_i), .dbiterr_i(dbiterr_i), .locked_o(locked_o),
    .word_cnt_o(word_cnt_o), .mis_cnt_o(mis_cnt_o), .sbit_cnt_o(sbit_cnt_o),
    .dbit_cnt_o(dbit_cnt_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // ---------------- FIFO model (non-FWFT, registered empty) ----------------
  typedef struct {
    logic [31:0] d;
    bit          s;
    bit          db;
    bit          clr;
  } fw_t;

  fw_t q[$];
  fw_t w;
  int  cyc = 0;
  int  rd_viol = 0;
  bit  toggle_en = 1'b0;
  bit  clr_fired = 1'b0;
  bit  stall;

  always @(posedge clk) begin
    clear_auto <= 1'b0;
    sbiterr_i  <= 1'b0;
    dbiterr_i  <= 1'b0;
    if (fifo_rd_en_o) begin
      if (fifo_empty_i || q.size() == 0) begin
        rd_viol++;
      end else begin
        w = q.pop_front();
        fifo_dout_i <= w.d;
        sbiterr_i   <= w.s;
        dbiterr_i   <= w.db;
        if (w.clr) begin
          clear_auto <= 1'b1;
          clr_fired  = 1'b1;
        end
      end
    end
    stall = toggle_en && (((cyc / 7) % 2) == 1);
    fifo_empty_i <= (q.size() == 0) || stall;
    cyc++;
  end

  // ---------------- checking helpers ----------------
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp_v);
    end
  endtask

  task automatic push_w(input logic [31:0] d, input bit s, input bit db, input bit clr);
    fw_t e;
    e.d = d; e.s = s; e.db = db; e.clr = clr;
    q.push_back(e);
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drain"}, q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_rd_en"},  {31'd0, fifo_rd_en_o}, 32'd0);
    chk({nm, "_locked"}, {31'd0, locked_o},     32'd0);
    chk({nm, "_err"},    {31'd0, err_o},        32'd0);
    chk({nm, "_word"},   word_cnt_o,            32'd0);
    chk({nm, "_mis"},    {16'd0, mis_cnt_o},    32'd0);
    chk({nm, "_sbit"},   {16'd0, sbit_cnt_o},   32'd0);
    chk({nm, "_dbit"},   {16'd0, dbit_cnt_o},   32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       nm;
    logic [31:0] start;
    int          len;
    int          bad_idx;
    logic [31:0] bad_val;
    int          dbit_idx;
    int          sbit_idx;
    bit          toggle;
    logic [31:0] e_word;
    logic [15:0] e_mis;
    logic [15:0] e_sbit;
    logic [15:0] e_dbit;
    bit          e_err;
  } rec_t;

  function automatic rec_t mk(input string nm, input logic [31:0] start, input int len,
                              input int bad_idx, input logic [31:0] bad_val,
                              input int dbit_idx, input int sbit_idx, input bit toggle,
                              input logic [31:0] e_word, input logic [15:0] e_mis,
                              input logic [15:0] e_sbit, input logic [15:0] e_dbit,
                              input bit e_err);
    rec_t r;
    r.nm = nm; r.start = start; r.len = len; r.bad_idx = bad_idx; r.bad_val = bad_val;
    r.dbit_idx = dbit_idx; r.sbit_idx = sbit_idx; r.toggle = toggle;
    r.e_word = e_word; r.e_mis = e_mis; r.e_sbit = e_sbit; r.e_dbit = e_dbit; r.e_err = e_err;
    return r;
  endfunction

  task automatic run_rec(input rec_t r);
    logic [31:0] d;
    en_i = 1'b0;
    repeat (3) @(negedge clk);
    chk({r.nm, "_idle_locked"}, {31'd0, locked_o}, 32'd0);
    clear_man = 1'b1;
    @(negedge clk);
    clear_man = 1'b0;
    for (int i = 0; i < r.len; i++) begin
      d = r.start + i;
      if (i == r.bad_idx) d = r.bad_val;
      push_w(d, (i == r.sbit_idx), (i == r.dbit_idx), 1'b0);
    end
    toggle_en = r.toggle;
    en_i = 1'b1;
    wait_drain(r.nm);
    toggle_en = 1'b0;
    chk({r.nm, "_locked"}, {31'd0, locked_o},   32'd1);
    chk({r.nm, "_word"},   word_cnt_o,          r.e_word);
    chk({r.nm, "_mis"},    {16'd0, mis_cnt_o},  {16'd0, r.e_mis});
    chk({r.nm, "_sbit"},   {16'd0, sbit_cnt_o}, {16'd0, r.e_sbit});
    chk({r.nm, "_dbit"},   {16'd0, dbit_cnt_o}, {16'd0, r.e_dbit});
    chk({r.nm, "_err"},    {31'd0, err_o},      {31'd0, r.e_err});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rec_t        recs[5];
    logic [15:0] slip_mis;
    logic [15:0] clr_mis;
    bit          clr_err;
    int          n;

`ifdef FIFO_CHK_RESYNC_EN
    slip_mis = 16'd2;
    clr_mis  = 16'd1;
    clr_err  = 1'b1;
`else
    slip_mis = 16'd1;
    clr_mis  = 16'd0;
    clr_err  = 1'b0;
`endif
    //           name      start          len bad  bad_val        dbit sbit tog word   mis       sb  db  err
    recs[0] = mk("count",  32'd0,         100, -1, 32'd0,         -1,  -1,  1,  32'd99, 16'd0,    0,  0,  0);
    recs[1] = mk("wrap",   32'hFFFF_FFFE, 4,   -1, 32'd0,         -1,  -1,  0,  32'd3,  16'd0,    0,  0,  0);
    recs[2] = mk("corrupt",32'd10,        10,  5,  32'h0000_DEAD, -1,  -1,  0,  32'd9,  slip_mis, 0,  0,  1);
    recs[3] = mk("ecc",    32'd0,         13,  5,  32'h0000_0BAD, 5,   8,   0,  32'd12, 16'd0,    1,  1,  1);
    recs[4] = mk("syncdb", 32'd0,         6,   0,  32'h0000_0777, 0,   -1,  0,  32'd4,  16'd0,    0,  0,  0);

    // Reset state.
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_i = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_rec(recs[i]);
    chk("no_rd_while_empty", rd_viol, 0);

    // Clear pulse in the same cycle the mismatching word is processed.
    en_i = 1'b0;
    repeat (3) @(negedge clk);
    push_w(32'd100, 0, 0, 0);
    push_w(32'd101, 0, 0, 0);
    push_w(32'h55,  0, 0, 1);
    push_w(32'd103, 0, 0, 0);
    push_w(32'd104, 0, 0, 0);
    push_w(32'd105, 0, 0, 0);
    clr_fired = 1'b0;
    en_i = 1'b1;
    n = 0;
    while (!clr_fired && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("clr_seen", {31'd0, clr_fired}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("clr_word", word_cnt_o,          32'd0);
    chk("clr_mis",  {16'd0, mis_cnt_o},  32'd0);
    chk("clr_err",  {31'd0, err_o},      32'd0);
    wait_drain("clr");
    chk("clr_after_word", word_cnt_o,          32'd3);
    chk("clr_after_mis",  {16'd0, mis_cnt_o},  {16'd0, clr_mis});
    chk("clr_after_err",  {31'd0, err_o},      {31'd0, clr_err});

    // Reset mid-stream with a read in flight, then resynchronise.
    en_i = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 50; i++) push_w(32'd200 + i, 0, 0, 0);
    en_i = 1'b1;
    n = 0;
    while (word_cnt_o < 32'd10 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rst_progress", {31'd0, (word_cnt_o >= 32'd10)}, 32'd1);
    n = 0;
    while (!fifo_rd_en_o && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rst_inflight", {31'd0, fifo_rd_en_o}, 32'd1);
    rst_i = 1'b1;
    @(negedge clk);
    chk_reset_vals("midrst");
    rst_i = 1'b0;
    en_i  = 1'b0;
    q.delete();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 21; i++) push_w(32'd500 + i, 0, 0, 0);
    en_i = 1'b1;
    wait_drain("resync");
    chk("resync_locked", {31'd0, locked_o},  32'd1);
    chk("resync_word",   word_cnt_o,         32'd20);
    chk("resync_mis",    {16'd0, mis_cnt_o}, 32'd0);
    chk("resync_err",    {31'd0, err_o},     32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
